// File: rtl/rs_hs_pipeline_credit_sched.sv
// Head-side scheduler for a credit-controlled relay-station pipeline: round-robin
// arbitration over NUM_REQ requesters, one registered issue per cycle, enable/drain sequencing.
module rs_hs_pipeline_credit_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int CREDITS    = 24,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int CNT_WIDTH  = $clog2(CREDITS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  input  logic                          credit_return,
  output logic [CNT_WIDTH-1:0]          credit_count,
  output logic                          idle,
  output logic                          err_overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(CREDITS);

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] win;
  logic                grant;
  logic                xfer;
  int                  cand;

  // A transfer and a return in the same cycle cancel; a lone return at full saturates.
  function automatic logic [CNT_WIDTH-1:0] next_credit(input logic [CNT_WIDTH-1:0] cnt,
                                                       input logic take,
                                                       input logic give);
    logic [CNT_WIDTH-1:0] res;
    res = cnt;
    if (take && !give)
      res = cnt - CNT_WIDTH'(1);
    else if (give && !take && cnt != CNT_FULL)
      res = cnt + CNT_WIDTH'(1);
    return res;
  endfunction

  function automatic logic credit_overflow(input logic [CNT_WIDTH-1:0] cnt,
                                           input logic take,
                                           input logic give);
    return give && !take && (cnt == CNT_FULL);
  endfunction

  // Stage p0: round-robin search starting just after the last winner
  always_comb begin
    win  = '0;
    cand = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[cand[ID_WIDTH-1:0]])
        win = cand[ID_WIDTH-1:0];
    end
  end

  assign grant = (state == S_RUN) && (credit_count != '0) && (|req_valid);

  always_comb begin
    req_ready = '0;
    if (grant)
      req_ready[win] = 1'b1;
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (enable) state_next = S_RUN;
      S_RUN:   if (!enable) state_next = S_DRAIN;
      S_DRAIN: begin
        if (enable)
          state_next = S_RUN;
        else if (credit_count == CNT_FULL && !out_valid)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Stage p1: registered issue into the pipeline head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      credit_count <= CNT_FULL;
      rr_ptr       <= ID_WIDTH'(NUM_REQ - 1);
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_id       <= '0;
      err_overflow <= 1'b0;
      idle         <= 1'b1;
    end else begin
      state        <= state_next;
      idle         <= (state == S_IDLE);
      out_valid    <= xfer;
      credit_count <= next_credit(credit_count, xfer, credit_return);
      if (credit_overflow(credit_count, xfer, credit_return))
        err_overflow <= 1'b1;
      if (xfer) begin
        rr_ptr   <= win;
        out_id   <= win;
        out_data <= req_data[win*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_rs_hs_pipeline_credit_sched.sv
// Directed bench for rs_hs_pipeline_credit_sched: burst to empty, single-credit refill,
// simultaneous take/return, drain/resume, overflow flag and asynchronous reset.
module tb_rs_hs_pipeline_credit_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_id;
  logic         credit_return;
  logic [4:0]   credit_count;
  logic         idle;
  logic         err_overflow;

  int n_chk  = 0;
  int n_pass = 0;

  rs_hs_pipeline_credit_sched #(
    .DATA_WIDTH(32), .NUM_REQ(4), .CREDITS(24)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .credit_return(credit_return), .credit_count(credit_count),
    .idle(idle), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    req_valid     = 4'h0;
    credit_return = 1'b0;
    req_data      = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    #2;
    check("rst_count", 32'(credit_count), 32'd24);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;

    // Burst of 24 issues, strict 0,1,2,3 rotation
    #1 enable = 1'b1;
    req_valid = 4'hF;
    #1 check("idle_noready", 32'(req_ready), 32'd0);
    step();
    for (int k = 0; k < 24; k++) begin
      check("burst_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      step();
      check("burst_valid", 32'(out_valid), 32'd1);
      check("burst_id", 32'(out_id), 32'(k % 4));
      check("burst_data", out_data, 32'hA0 + 32'(k % 4));
      check("burst_count", 32'(credit_count), 32'(23 - k));
    end
    check("empty_noready", 32'(req_ready), 32'd0);
    step();
    check("empty_valid", 32'(out_valid), 32'd0);
    check("empty_id_hold", 32'(out_id), 32'd3);

    // Single credit refill -> one grant to requester 0
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    check("refill_count", 32'(credit_count), 32'd1);
    check("refill_ready", 32'(req_ready), 32'b0001);
    step();
    check("refill_valid", 32'(out_valid), 32'd1);
    check("refill_id", 32'(out_id), 32'd0);
    check("refill_count0", 32'(credit_count), 32'd0);

    // Build 10 credits, then take and return together
    req_valid     = 4'h0;
    credit_return = 1'b1;
    repeat (10) step();
    check("ten_count", 32'(credit_count), 32'd10);
    req_valid = 4'hF;
    #1 check("both_ready", 32'(req_ready), 32'b0010);
    step();
    check("both_count", 32'(credit_count), 32'd10);
    check("both_valid", 32'(out_valid), 32'd1);
    check("both_id", 32'(out_id), 32'd1);
    check("both_data", out_data, 32'hA1);
    req_valid = 4'h0;
    repeat (9) step();
    credit_return = 1'b0;
    check("c19_count", 32'(credit_count), 32'd19);

    // Drain, then resume from rr_ptr+1
    enable = 1'b0;
    step();
    req_valid = 4'hF;
    #1 check("drain_noready", 32'(req_ready), 32'd0);
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    check("drain_count", 32'(credit_count), 32'd20);
    check("drain_noready2", 32'(req_ready), 32'd0);
    enable = 1'b1;
    step();
    check("resume_ready", 32'(req_ready), 32'b0100);
    step();
    check("resume_id", 32'(out_id), 32'd2);
    check("resume_count", 32'(credit_count), 32'd19);

    // Drain with 5 outstanding credits down to IDLE
    req_valid = 4'h0;
    enable    = 1'b0;
    step();
    check("drain5_valid", 32'(out_valid), 32'd0);
    req_valid = 4'hF;
    #1 check("drain5_noready", 32'(req_ready), 32'd0);
    credit_return = 1'b1;
    repeat (5) step();
    credit_return = 1'b0;
    check("drain5_count", 32'(credit_count), 32'd24);
    check("drain5_notidle", 32'(idle), 32'd0);
    step();
    check("idle_lag", 32'(idle), 32'd0);
    step();
    check("idle_set", 32'(idle), 32'd1);

    // Overflow at full count, then async reset mid-burst
    req_valid     = 4'h0;
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    check("ovf_count", 32'(credit_count), 32'd24);
    check("ovf_err", 32'(err_overflow), 32'd1);
    step();
    check("ovf_sticky", 32'(err_overflow), 32'd1);
    enable    = 1'b1;
    req_valid = 4'hF;
    step();
    step();
    check("post_id3", 32'(out_id), 32'd3);
    check("post_count", 32'(credit_count), 32'd23);
    step();
    check("post_id0", 32'(out_id), 32'd0);
    check("post_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(credit_count), 32'd24);
    check("arst_err", 32'(err_overflow), 32'd0);
    check("arst_idle", 32'(idle), 32'd1);
    check("arst_id", 32'(out_id), 32'd0);
    check("arst_data", out_data, 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
